// File: rtl/card_pkg.sv
// Shared constants and types for the card sprite blitter.
package card_pkg;

  localparam int unsigned CARD_W   = 16;
  localparam int unsigned CARD_H   = 32;
  localparam int unsigned SCREEN_W = 256;
  localparam int unsigned SCREEN_H = 240;
  localparam int unsigned COLOR_W  = 3;

  localparam int unsigned COL_W   = $clog2(CARD_W);
  localparam int unsigned ROW_W   = $clog2(CARD_H);
  localparam int unsigned CADDR_W = COL_W + ROW_W;

  typedef logic [COLOR_W-1:0] color_t;

  localparam color_t TRANSPARENT = 3'b000;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN,
    DONE
  } blit_state_t;

endpackage

// File: rtl/card_blit_clip.sv
// Screen address packing, clipping and transparency test for one texel.
module card_blit_clip
  import card_pkg::*;
(
  input  logic [7:0]       x_org,
  input  logic [7:0]       y_org,
  input  logic [COL_W-1:0] col,
  input  logic [ROW_W-1:0] row,
  input  color_t           texel,
  input  logic             valid,
  output logic             we,
  output logic [15:0]      waddr
);

  logic [8:0] sx;
  logic [8:0] sy;

  // 9-bit sums so that running off the right/bottom edge is rejected, never wrapped
  always_comb begin
    sx    = {1'b0, x_org} + 9'(col);
    sy    = {1'b0, y_org} + 9'(row);
    we    = valid && (texel != TRANSPARENT) &&
            (sx < 9'(SCREEN_W)) && (sy < 9'(SCREEN_H));
    waddr = {sy[7:0], sx[7:0]};
  end

endmodule

// File: rtl/card_blit.sv
// Streams one 16x32 card out of card RAM into the framebuffer at (xPos,yPos).
module card_blit
  import card_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  xPos,
  input  logic [7:0]  yPos,
  output logic        card_RE,
  output logic [8:0]  card_rAddr,
  input  logic [2:0]  card_dataIn,
  output logic        fb_WE,
  output logic [15:0] fb_wAddr,
  output logic [2:0]  fb_dataOut,
  output logic        busy,
  output logic        done
);

  localparam logic [8:0] LAST_ADDR = 9'(CARD_W * CARD_H - 1);

  blit_state_t state, next_state;

  logic [8:0]       addr;
  logic [7:0]       x_org;
  logic [7:0]       y_org;
  logic             pipe_valid;
  logic [COL_W-1:0] pipe_col;
  logic [ROW_W-1:0] pipe_row;
  logic             clip_we;
  logic [15:0]      clip_waddr;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = READ;
      READ:    if (addr == LAST_ADDR) next_state = DRAIN;
      DRAIN:   next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    card_RE    = (state == READ);
    card_rAddr = addr;
  end

  card_blit_clip u_clip (
    .x_org (x_org),
    .y_org (y_org),
    .col   (pipe_col),
    .row   (pipe_row),
    .texel (card_dataIn),
    .valid (pipe_valid),
    .we    (clip_we),
    .waddr (clip_waddr)
  );

  // busy/done come from next_state so they line up with the state they describe
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      addr       <= '0;
      x_org      <= '0;
      y_org      <= '0;
      pipe_valid <= 1'b0;
      pipe_col   <= '0;
      pipe_row   <= '0;
      fb_WE      <= 1'b0;
      fb_wAddr   <= '0;
      fb_dataOut <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      if (state == IDLE && start) begin
        addr  <= '0;
        x_org <= xPos;
        y_org <= yPos;
      end else if (state == READ) begin
        addr <= addr + 9'd1;
      end
      pipe_valid <= (state == READ);
      pipe_col   <= addr[COL_W-1:0];
      pipe_row   <= addr[CADDR_W-1:COL_W];
      fb_WE      <= clip_we;
      fb_wAddr   <= clip_waddr;
      fb_dataOut <= card_dataIn;
      busy       <= (next_state == READ) || (next_state == DRAIN);
      done       <= (next_state == DONE);
    end
  end

endmodule

// File: tb/tb_card_blit.sv
// Directed and randomized checks of card_blit against a texel-level reference model.
module tb_card_blit;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  xPos = '0;
  logic [7:0]  yPos = '0;
  logic        card_RE;
  logic [8:0]  card_rAddr;
  logic [2:0]  card_dataIn = '0;
  logic        fb_WE;
  logic [15:0] fb_wAddr;
  logic [2:0]  fb_dataOut;
  logic        busy;
  logic        done;

  card_blit dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .xPos        (xPos),
    .yPos        (yPos),
    .card_RE     (card_RE),
    .card_rAddr  (card_rAddr),
    .card_dataIn (card_dataIn),
    .fb_WE       (fb_WE),
    .fb_wAddr    (fb_wAddr),
    .fb_dataOut  (fb_dataOut),
    .busy        (busy),
    .done        (done)
  );

  always #5 clock = ~clock;

  logic [2:0]  mem [512];
  logic [18:0] obs_q [$];
  logic [18:0] exp_q [$];
  int          done_pulses = 0;
  int          checks = 0;
  int          errors = 0;

  // card RAM: synchronous read, data valid the cycle after card_RE
  always @(posedge clock) if (card_RE) card_dataIn <= mem[card_rAddr];

  always @(negedge clock) begin
    if (fb_WE) obs_q.push_back({fb_wAddr, fb_dataOut});
    if (done) done_pulses++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic fill(input int mode);
    for (int a = 0; a < 512; a++) begin
      case (mode)
        0:       mem[a] = 3'b111;
        1:       mem[a] = (a % 2 == 1) ? 3'b101 : 3'b000;
        default: mem[a] = 3'($urandom_range(0, 7));
      endcase
    end
  endtask

  task automatic build_expected(input int x, input int y);
    exp_q.delete();
    for (int a = 0; a < 512; a++) begin
      int sx;
      int sy;
      sx = x + (a % 16);
      sy = y + (a / 16);
      if (mem[a] != 3'b000 && sx < 256 && sy < 240)
        exp_q.push_back({sy[7:0], sx[7:0], mem[a]});
    end
  endtask

  task automatic run_blit(input string tag, input int x, input int y, input bit inject);
    int n;
    int bad;
    build_expected(x, y);
    @(negedge clock);
    obs_q.delete();
    done_pulses = 0;
    start = 1'b1;
    xPos  = 8'(x);
    yPos  = 8'(y);
    @(posedge clock);
    #1 start = 1'b0;
    check({tag, "_busy_start"}, 32'(busy), 32'd1);
    check({tag, "_first_read"}, {22'd0, card_RE, card_rAddr}, {22'd0, 1'b1, 9'd0});
    n = 0;
    while (n < 600 && !done) begin
      @(posedge clock);
      #1 n++;
      if (inject && n == 50) begin
        start = 1'b1;
        xPos  = 8'(x + 77);
        yPos  = 8'(y + 33);
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    check({tag, "_done_latency"}, 32'(n), 32'd513);
    check({tag, "_busy_in_done"}, 32'(busy), 32'd0);
    @(posedge clock);
    #1 check({tag, "_done_width"}, 32'(done), 32'd0);
    repeat (2) @(posedge clock);
    #1 check({tag, "_write_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
    bad = 0;
    for (int i = 0; i < obs_q.size(); i++)
      if (i >= exp_q.size() || obs_q[i] !== exp_q[i]) bad++;
    check({tag, "_write_seq"}, 32'(bad), 32'd0);
    check({tag, "_done_pulses"}, 32'(done_pulses), 32'd1);
  endtask

  initial begin
    int n;
    int cnt;
    logic [15:0] mx;

    repeat (3) @(posedge clock);
    #1 check("reset_outputs",
             {4'd0, card_RE, card_rAddr, fb_WE, fb_wAddr, fb_dataOut, busy, done},
             32'd0);
    @(negedge clock) reset = 1'b0;

    fill(0);
    run_blit("opaque_0_0", 0, 0, 1'b0);
    check("opaque_count", 32'(obs_q.size()), 32'd512);
    check("opaque_first", 32'(obs_q[0][18:3]), 32'h0000);
    check("opaque_last", 32'(obs_q[obs_q.size()-1][18:3]), 32'h1F0F);

    fill(1);
    run_blit("checker_40_100", 40, 100, 1'b0);
    check("checker_count", 32'(obs_q.size()), 32'd256);
    check("checker_first", 32'(obs_q[0][18:3]), 32'h6429);
    cnt = 0;
    foreach (obs_q[i]) if (obs_q[i][2:0] != 3'b101) cnt++;
    check("checker_colour", 32'(cnt), 32'd0);

    fill(0);
    run_blit("clip_x", 250, 0, 1'b0);
    check("clip_x_count", 32'(obs_q.size()), 32'd192);
    cnt = 0;
    foreach (obs_q[i]) if (obs_q[i][10:3] < 8'd250) cnt++;
    check("clip_x_nowrap", 32'(cnt), 32'd0);

    run_blit("clip_y", 0, 220, 1'b0);
    check("clip_y_count", 32'(obs_q.size()), 32'd320);
    mx = '0;
    cnt = 0;
    foreach (obs_q[i]) begin
      if (obs_q[i][18:3] > mx) mx = obs_q[i][18:3];
      if (obs_q[i][18:11] >= 8'd240) cnt++;
    end
    check("clip_y_max", 32'(mx), 32'hEF0F);
    check("clip_y_nowrap", 32'(cnt), 32'd0);

    run_blit("restart_ignored", 10, 20, 1'b1);
    check("restart_count", 32'(obs_q.size()), 32'd512);

    @(negedge clock);
    start = 1'b1;
    xPos  = '0;
    yPos  = '0;
    @(posedge clock);
    #1 start = 1'b0;
    n = 0;
    while (n < 200 && card_rAddr != 9'd100) begin
      @(posedge clock);
      #1 n++;
    end
    check("midblit_addr", 32'(card_rAddr), 32'd100);
    check("midblit_writing", {29'd0, card_RE, fb_WE, busy}, 32'd7);
    #2 reset = 1'b1;
    #1 check("async_reset", {29'd0, card_RE, fb_WE, busy}, 32'd0);
    @(negedge clock) reset = 1'b0;
    run_blit("after_reset", 5, 7, 1'b0);
    check("after_reset_count", 32'(obs_q.size()), 32'd512);

    for (int t = 0; t < 4; t++) begin
      fill(2);
      run_blit($sformatf("random%0d", t), int'($urandom_range(0, 255)),
               int'($urandom_range(0, 255)), 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
